// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: round-robin shared registered OR/NOR unit for NREQ requesters.
// Define GATE_ARB_STATS_EN to add the saturating grant_cnt transfer counter.
module gate_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int W = 8,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    input  logic [NREQ-1:0]   req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_z,
    output logic [IDW-1:0]    rsp_id
`ifdef GATE_ARB_STATS_EN
   ,output logic [15:0]       grant_cnt
`endif
);
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic           gnt_ok;
    logic           free;
    logic           xfer;
    logic [W-1:0]   gor;

    // Scan downward so the last hit, nearest to ptr, wins.
    always_comb begin
        gnt_ok = 1'b0;
        gnt_id = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(int'(ptr) + k) % NREQ]) begin
                gnt_ok = 1'b1;
                gnt_id = IDW'((int'(ptr) + k) % NREQ);
            end
    end

    assign free      = !rsp_valid || rsp_ready;
    assign xfer      = rst_n && free && gnt_ok;
    assign req_ready = xfer ? (NREQ'(1) << gnt_id) : '0;
    assign gor       = req_x[gnt_id*W +: W] | req_y[gnt_id*W +: W];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_z     <= '0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_z     <= req_op[gnt_id] ? ~gor : gor;
            rsp_id    <= gnt_id;
            ptr       <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
        end else if (rsp_ready)
            rsp_valid <= 1'b0;

`ifdef GATE_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            grant_cnt <= '0;
        else if (xfer && grant_cnt != 16'hFFFF)
            grant_cnt <= grant_cnt + 16'd1;
`endif
endmodule
